fifo_word_packer: RTL and testbench

//  Downstream consumer of the synchronous byte FIFO. Pops DATA_WIDTH-bit entries via the FIFO's
//  rd_en/empty/data_out interface (data valid one cycle after rd_en) and packs PACK_RATIO entries into
//  one wide word, presented on a valid/ready output. Partial words are flushed on idle timeout or on request.

---
 rtl/fifo_word_packer.sv | 131 +++++++++++++
 tb/tb_fifo_word_packer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Pops lanes from a synchronous FIFO and packs PACK_RATIO lanes into one word on a valid/ready output.
// Partial words go out on idle timeout or on a flush pulse. A full word costs one bubble cycle.
module fifo_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PACK_RATIO     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  input  logic                             flush,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep,
  output logic                             m_partial
);

  localparam int LW  = $clog2(PACK_RATIO + 1);
  localparam int IXW = $clog2(PACK_RATIO);
  localparam int IW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(PACK_RATIO);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {FILL, HOLD, FLUSH} state_t;

  state_t                                 state;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]  acc;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]  acc_cap;
  logic [LW-1:0]                          lane_cnt;
  logic [LW-1:0]                          lane_cap;
  logic                                   pend;
  logic                                   flush_req;
  logic [IW-1:0]                          idle_cnt;
  logic                                   slot_free;
  logic                                   word_done;
  logic                                   timeout_hit;
  logic                                   partial_go;
  logic [PACK_RATIO-1:0]                  keep_part;

  always_comb begin
    fifo_rd_en = rst_n && !fifo_empty && (state == FILL) && !flush_req &&
                 (((LW+1)'(lane_cnt) + (LW+1)'(pend)) < (LW+1)'(PACK_RATIO));
    acc_cap  = acc;
    lane_cap = lane_cnt;
    if (pend) begin
      acc_cap[lane_cnt[IXW-1:0]] = fifo_rd_data;
      lane_cap = lane_cnt + LW'(1);
    end
    word_done = pend && (lane_cap == FULL_CNT);
    slot_free = !m_valid || m_ready;
    // A pop issued on the timeout cycle is progress; flushing then would strand its data.
    timeout_hit = (TIMEOUT_CYCLES != 0) && (idle_cnt == IDLE_MAX) && !fifo_rd_en;
    partial_go  = (lane_cnt != '0) && !pend && (flush_req || timeout_hit);
    for (int i = 0; i < PACK_RATIO; i++) begin
      keep_part[i] = (LW'(i) < lane_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      acc       <= '0;
      lane_cnt  <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      idle_cnt  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_partial <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (flush) flush_req <= 1'b1;
      case (state)
        FILL: begin
          acc      <= acc_cap;
          lane_cnt <= lane_cap;
          if (pend || (lane_cnt == '0)) idle_cnt <= '0;
          else if (!fifo_rd_en && (idle_cnt != IDLE_MAX)) idle_cnt <= idle_cnt + IW'(1);
          if (word_done) begin
            flush_req <= 1'b0;
            if (slot_free) begin
              m_valid   <= 1'b1;
              m_data    <= acc_cap;
              m_keep    <= '1;
              m_partial <= 1'b0;
              lane_cnt  <= '0;
              acc       <= '0;
            end else begin
              state <= HOLD;
            end
          end else if (partial_go) begin
            state <= FLUSH;
          end else if (flush_req && (lane_cnt == '0) && !pend) begin
            flush_req <= 1'b0;
          end
        end
        HOLD: begin
          if (slot_free) begin
            m_valid   <= 1'b1;
            m_data    <= acc;
            m_keep    <= '1;
            m_partial <= 1'b0;
            lane_cnt  <= '0;
            acc       <= '0;
            state     <= FILL;
          end
        end
        FLUSH: begin
          if (slot_free) begin
            m_valid   <= 1'b1;
            m_data    <= acc;
            m_keep    <= keep_part;
            m_partial <= 1'b1;
            lane_cnt  <= '0;
            acc       <= '0;
            flush_req <= 1'b0;
            idle_cnt  <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Drives fifo_word_packer from a queue-backed FIFO model; expected words come from chunking pushed bytes.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        flush = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_partial;

  always #5 clk = ~clk;

  fifo_word_packer #(.DATA_WIDTH(8), .PACK_RATIO(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_partial(m_partial)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        p;
  } word_t;

  logic [7:0] fifo_q[$];
  logic [7:0] burst[$];
  word_t      sb[$];
  int tests_run = 0, fails = 0;
  int pops = 0, words = 0, valid_cycles = 0, cyc = 0, last_acc = -10, b2b = 0;
  bit rand_ready = 1'b0;
  bit hold_prev = 1'b0;
  logic [37:0] prev_out = '0;

  // Reference: bytes of one burst, in pop order, four per word; any remainder is a flushed partial.
  task automatic model_burst();
    word_t w;
    int n;
    n = 0;
    w = '0;
    foreach (burst[i]) begin
      w.d[8*n +: 8] = burst[i];
      n++;
      if (n == 4) begin
        w.k = 4'hF; w.p = 1'b0;
        sb.push_back(w);
        w = '0; n = 0;
      end
    end
    if (n > 0) begin
      w.k = 4'((1 << n) - 1); w.p = 1'b1;
      sb.push_back(w);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_ready) m_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic wait_drain(input int limit, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < limit) begin
      tick();
      n++;
    end
    tests_run++;
    assert (sb.size() === 0)
      else begin fails++; $error("FAIL %s_drain pending=%0d want=0", tag, sb.size()); end
  endtask

  // Monitor and FIFO model: sample 2 time units before the rising edge, update FIFO after it.
  always @(negedge clk) begin
    logic pop_s;
    word_t want_w;
    #3;
    cyc++;
    pop_s = fifo_rd_en;
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      tests_run++;
      assert ((fifo_rd_en & fifo_empty) === 1'b0)
        else begin fails++; $error("FAIL rd_en_while_empty got=%b want=0", fifo_rd_en & fifo_empty); end
      if (fifo_rd_en) pops++;
      if (m_valid) valid_cycles++;
      if (hold_prev) begin
        tests_run++;
        assert ({m_valid, m_data, m_keep, m_partial} === prev_out)
          else begin fails++; $error("FAIL hold_stable got=%h want=%h", {m_valid, m_data, m_keep, m_partial}, prev_out); end
      end
      if (m_valid && m_ready) begin
        words++;
        if (cyc == last_acc + 1) b2b++;
        last_acc = cyc;
        tests_run++;
        if (sb.size() == 0) begin
          fails++;
          $error("FAIL unexpected_word got=%h/%b/%b want=none", m_data, m_keep, m_partial);
        end else begin
          want_w = sb.pop_front();
          assert ({m_data, m_keep, m_partial} === want_w)
            else begin fails++; $error("FAIL word got=%h/%b/%b want=%h/%b/%b", m_data, m_keep, m_partial, want_w.d, want_w.k, want_w.p); end
        end
      end
      hold_prev = m_valid && !m_ready;
      prev_out  = {m_valid, m_data, m_keep, m_partial};
    end
    @(posedge clk);
    #1;
    if (pop_s) fifo_rd_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
    fifo_empty = (fifo_q.size() == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, p0, b0, v0, n;
    repeat (3) tick();
    fifo_empty = 1'b0;
    #1;
    tests_run++;
    assert ({m_valid, m_data, m_keep, m_partial, fifo_rd_en} === 39'd0)
      else begin fails++; $error("FAIL reset_outputs got=%h want=0", {m_valid, m_data, m_keep, m_partial, fifo_rd_en}); end
    fifo_empty = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // T1: one full word, single valid pulse
    m_ready = 1'b1;
    w0 = words;
    sb.push_back({32'h44332211, 4'hF, 1'b0});
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_drain(40, "t1");
    repeat (3) tick();
    tests_run++;
    assert (words - w0 === 1) else begin fails++; $error("FAIL t1_word_count got=%0d want=1", words - w0); end

    // T2: backpressure holds first word, exactly 8 pops, then back-to-back
    m_ready = 1'b0;
    p0 = pops;
    sb.push_back({32'h04030201, 4'hF, 1'b0});
    sb.push_back({32'h08070605, 4'hF, 1'b0});
    for (int i = 1; i <= 8; i++) push(8'(i));
    repeat (12) tick();
    tests_run++;
    assert (pops - p0 === 8) else begin fails++; $error("FAIL t2_pops got=%0d want=8", pops - p0); end
    tests_run++;
    assert ({m_valid, m_data, m_keep} === {1'b1, 32'h04030201, 4'hF})
      else begin fails++; $error("FAIL t2_held got=%b/%h/%b want=1/04030201/1111", m_valid, m_data, m_keep); end
    b0 = b2b;
    m_ready = 1'b1;
    wait_drain(20, "t2");
    tests_run++;
    assert (b2b - b0 === 1) else begin fails++; $error("FAIL t2_back_to_back got=%0d want=1", b2b - b0); end
    tests_run++;
    assert (pops - p0 === 8) else begin fails++; $error("FAIL t2_pops_total got=%0d want=8", pops - p0); end

    // T3: idle timeout flushes two lanes
    w0 = words;
    sb.push_back({32'h0000BBAA, 4'b0011, 1'b1});
    push(8'hAA); push(8'hBB);
    repeat (12) tick();
    tests_run++;
    assert (words === w0) else begin fails++; $error("FAIL t3_early_flush got=%0d want=%0d", words, w0); end
    wait_drain(40, "t3");

    // T4: flush while the pop is pending, then a flush with nothing buffered
    w0 = words;
    sb.push_back({32'h0000005A, 4'b0001, 1'b1});
    push(8'h5A);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (6) tick();
    tests_run++;
    assert (words - w0 === 1) else begin fails++; $error("FAIL t4_flush_word got=%0d want=1", words - w0); end
    wait_drain(20, "t4");
    w0 = words;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (10) tick();
    tests_run++;
    assert ({words, m_valid} === {w0, 1'b0})
      else begin fails++; $error("FAIL t4_empty_flush got=%0d/%b want=%0d/0", words, m_valid, w0); end

    // T5: FIFO empty with random ready/flush
    rand_ready = 1'b1;
    v0 = valid_cycles;
    p0 = pops;
    repeat (60) begin
      flush = ($urandom_range(0, 3) == 0);
      tick();
    end
    flush = 1'b0;
    tests_run++;
    assert ({valid_cycles - v0, pops - p0} === 64'd0)
      else begin fails++; $error("FAIL t5_idle got=%0d/%0d want=0/0", valid_cycles - v0, pops - p0); end

    // T6: reset mid-word discards lanes; next four bytes form a clean word
    rand_ready = 1'b0;
    m_ready = 1'b1;
    push(8'h91); push(8'h92); push(8'h93);
    repeat (6) tick();
    rst_n = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    #1;
    tests_run++;
    assert ({m_valid, m_data, m_keep, m_partial, fifo_rd_en} === 39'd0)
      else begin fails++; $error("FAIL t6_reset got=%h want=0", {m_valid, m_data, m_keep, m_partial, fifo_rd_en}); end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    sb.push_back({32'hD4C3B2A1, 4'hF, 1'b0});
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    wait_drain(40, "t6");

    // Random bursts with random downstream readiness
    rand_ready = 1'b1;
    repeat (8) begin
      n = $urandom_range(1, 11);
      burst.delete();
      for (int i = 0; i < n; i++) burst.push_back(8'($urandom));
      model_burst();
      foreach (burst[i]) begin
        push(burst[i]);
        tick();
        repeat ($urandom_range(0, 3)) tick();
      end
      wait_drain(300, "rand");
    end
    rand_ready = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
